// File: rtl/swi_pkg.sv
// Shared types and defaults for the switch-bank event reader.
// Build option: define SWI_DEBOUNCE_EN to enable per-bit debounce counters.
package swi_pkg;

  localparam int NBITS_DEF      = 8;
  localparam int DEBOUNCE_DEF   = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic int idxw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDXW = idxw(NBITS_DEF);

  typedef struct packed {
    logic            dir;
    logic [IDXW-1:0] idx;
  } swi_event_t;

endpackage

// File: rtl/swi_event_fifo.sv
// Small event queue: push when not full (or popping), valid/ready pop.
// Output data is forced to zero while empty.
module swi_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             pop;
  logic             wr;

  assign valid = cnt != '0;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign pop   = valid && ready;
  assign wr    = push && (!full || pop);
  assign rdata = valid ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      unique case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/swi_event_reader.sv
// Switch bank front end: sync, debounce, edge pulses, queued change events.
// Build option: SWI_DEBOUNCE_EN enables debounce counters (else direct load).
module swi_event_reader
  import swi_pkg::*;
#(
  parameter int NBITS           = NBITS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic [NBITS-1:0]      SWI,
  output logic [NBITS-1:0]      sw_stable,
  output logic [NBITS-1:0]      sw_rise,
  output logic [NBITS-1:0]      sw_fall,
  output logic                  ev_valid,
  output logic [idxw(NBITS):0]  ev_data,
  input  logic                  ev_ready,
  output logic                  ev_lost
);

  localparam int IW = idxw(NBITS);

  logic [NBITS-1:0] s1;
  logic [NBITS-1:0] s2;
  logic [NBITS-1:0] flip;
  logic [NBITS-1:0] pend;
  logic [NBITS-1:0] pdir;
  logic [NBITS-1:0] clr;
  logic [IW-1:0]    sel;
  logic             found;
  logic             full;
  logic             pop;
  logic             push;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= SWI;
      s2 <= s1;
    end
  end

`ifdef SWI_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt [NBITS];

  always_comb begin
    flip = '0;
    for (int i = 0; i < NBITS; i++) begin
      flip[i] = (s2[i] != sw_stable[i]) &&
                (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk_2) begin
    for (int i = 0; i < NBITS; i++) begin
      if (reset || s2[i] == sw_stable[i] || flip[i])
        cnt[i] <= '0;
      else
        cnt[i] <= cnt[i] + 1'b1;
    end
  end
`else
  assign flip = s2 ^ sw_stable;
`endif

  always_ff @(posedge clk_2) begin
    if (reset) begin
      sw_stable <= '0;
      sw_rise   <= '0;
      sw_fall   <= '0;
    end else begin
      sw_stable <= sw_stable ^ flip;
      sw_rise   <= flip & s2;
      sw_fall   <= flip & ~s2;
    end
  end

  // lowest pending index wins the single push slot
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  assign pop  = ev_valid && ev_ready;
  assign push = found && (!full || pop);
  assign clr  = push ? (NBITS'(1) << sel) : '0;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      pend    <= '0;
      pdir    <= '0;
      ev_lost <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | flip;
      pdir <= (pdir & ~flip) | (s2 & flip);
      if (|(pend & ~clr & flip)) ev_lost <= 1'b1;
    end
  end

  swi_event_fifo #(
    .WIDTH (IW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_2),
    .reset (reset),
    .push  (push),
    .wdata ({pdir[sel], sel}),
    .full  (full),
    .valid (ev_valid),
    .ready (ev_ready),
    .rdata (ev_data)
  );

endmodule

// File: tb/tb_swi_event_reader.sv
// Bench for swi_event_reader: table steps, corner sequences, random run
// checked every cycle against a window/queue reference model.
module tb_swi_event_reader;
  import swi_pkg::*;

  localparam int N     = 8;
  localparam int D     = 4;
  localparam int DEPTH = 4;
`ifdef SWI_DEBOUNCE_EN
  localparam int DEFF = D;
`else
  localparam int DEFF = 1;
`endif

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] SWI = 8'h00;
  logic [7:0] sw_stable;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       ev_valid;
  logic [3:0] ev_data;
  logic       ev_ready = 1'b0;
  logic       ev_lost;

  int errors = 0;
  int checks = 0;

  swi_event_reader #(
    .NBITS           (N),
    .DEBOUNCE_CYCLES (D),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .SWI       (SWI),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .ev_valid  (ev_valid),
    .ev_data   (ev_data),
    .ev_ready  (ev_ready),
    .ev_lost   (ev_lost)
  );

  always #5 clk_2 = ~clk_2;

  // reference model: input history window plus pending/queue bookkeeping
  logic [7:0] h[$];
  logic [7:0] m_stable, m_rise, m_fall, m_pend, m_pdir;
  logic [3:0] mq[$];
  bit         m_lost;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    h.delete();
    for (int j = 0; j <= DEFF; j++) h.push_back(8'h00);
    m_stable = '0; m_rise = '0; m_fall = '0;
    m_pend = '0; m_pdir = '0; m_lost = 0;
    mq.delete();
  endtask

  task automatic model_edge(input logic [7:0] swi, input bit rst,
                            input bit rdy);
    logic [7:0] flip;
    bit pop, found, dp, all;
    int sel;
    if (rst) begin
      model_reset();
      return;
    end
    flip = '0;
    for (int i = 0; i < N; i++) begin
      all = 1;
      for (int j = 1; j <= DEFF; j++)
        if (h[j][i] == m_stable[i]) all = 0;
      flip[i] = all;
    end
    pop = (mq.size() > 0) && rdy;
    found = 0; sel = 0;
    for (int i = N - 1; i >= 0; i--)
      if (m_pend[i]) begin found = 1; sel = i; end
    dp = found && (mq.size() < DEPTH || pop);
    if (pop) void'(mq.pop_front());
    if (dp) begin
      mq.push_back({m_pdir[sel], 3'(sel)});
      m_pend[sel] = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (flip[i]) begin
        if (m_pend[i]) m_lost = 1;
        m_pend[i] = 1'b1;
        m_pdir[i] = ~m_stable[i];
      end
    m_rise = flip & ~m_stable;
    m_fall = flip & m_stable;
    m_stable = m_stable ^ flip;
    h.push_front(swi);
    void'(h.pop_back());
  endtask

  task automatic step(input logic [7:0] swi, input bit rdy, input bit rst);
    SWI = swi; ev_ready = rdy; reset = rst;
    @(posedge clk_2);
    model_edge(swi, rst, rdy);
    #1;
    chk("stable", sw_stable, m_stable);
    chk("rise", sw_rise, m_rise);
    chk("fall", sw_fall, m_fall);
    chk("valid", ev_valid, mq.size() > 0);
    chk("data", ev_data, (mq.size() > 0) ? mq[0] : 4'h0);
    chk("lost", ev_lost, m_lost);
  endtask

  typedef struct {
    logic [7:0] swi;
    bit         rdy;
    int         cyc;
    logic [7:0] exp_stable;
    bit         exp_valid;
  } vec_t;

  vec_t vt[5];
  logic [3:0] got[$];
  logic [3:0] exp_ev[$];
  swi_event_t e;
  int lat;
  bit seen;

  initial begin
    model_reset();
    vt[0] = '{8'h00, 1, 20, 8'h00, 0};
    vt[1] = '{8'h08, 1, 12, 8'h08, 0};
    vt[2] = '{8'hA5, 1, 16, 8'hA5, 0};
    vt[3] = '{8'hFF, 1, 16, 8'hFF, 0};
    vt[4] = '{8'h00, 1, 16, 8'h00, 0};

    repeat (3) step(8'h00, 1, 1);

    foreach (vt[k]) begin
      for (int c = 0; c < vt[k].cyc; c++) step(vt[k].swi, vt[k].rdy, 0);
      chk($sformatf("tbl%0d_stable", k), sw_stable, vt[k].exp_stable);
      chk($sformatf("tbl%0d_valid", k), ev_valid, vt[k].exp_valid);
    end
    chk("tbl_lost", ev_lost, 0);

    // single rise latency and event
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      step(8'h08, 1, 0);
      if (sw_rise != 0) begin
        lat = c;
        chk("rise3_pulse", sw_rise, 8'h08);
      end
    end
    chk("rise3_latency", lat, 2 + DEFF);
    step(8'h08, 1, 0);
    chk("rise3_pulse_gone", sw_rise, 8'h00);
    chk("rise3_ev_valid", ev_valid, 1);
    e = ev_data;
    chk("rise3_ev_dir", e.dir, 1);
    chk("rise3_ev_idx", e.idx, 3);
    repeat (8) step(8'h00, 1, 0);

    // 3-cycle glitch
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      step((c < 3) ? 8'h01 : 8'h00, 1, 0);
      if (sw_rise[0]) seen = 1;
    end
    chk("glitch_rise", seen, (DEFF > 3) ? 1'b0 : 1'b1);

    // A5 burst: ascending events on consecutive cycles
    got.delete();
    for (int c = 0; c < 16; c++) begin
      if (ev_valid) got.push_back(ev_data);
      step(8'hA5, 1, 0);
    end
    exp_ev = '{4'h8, 4'hA, 4'hD, 4'hF};
    chk("a5_count", got.size(), 4);
    foreach (exp_ev[k])
      if (k < got.size()) chk($sformatf("a5_ev%0d", k), got[k], exp_ev[k]);
    repeat (10) step(8'h00, 1, 0);

    // full queue stall, overwrite of a pending bit, then drain
    repeat (12) step(8'h3F, 0, 0);
    chk("stall_valid", ev_valid, 1);
    chk("stall_lost0", ev_lost, 0);
    repeat (12) step(8'h1F, 0, 0);
    chk("stall_lost1", ev_lost, 1);
    got.delete();
    for (int c = 0; c < 12; c++) begin
      if (ev_valid) got.push_back(ev_data);
      step(8'h1F, 1, 0);
    end
    exp_ev = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'h5};
    chk("drain_count", got.size(), 6);
    foreach (exp_ev[k])
      if (k < got.size()) chk($sformatf("drain_ev%0d", k), got[k], exp_ev[k]);

    // reset mid-debounce with all switches high
    repeat (3) step(8'hFF, 1, 0);
    repeat (2) step(8'hFF, 1, 1);
    chk("rst_stable", sw_stable, 8'h00);
    chk("rst_valid", ev_valid, 0);
    chk("rst_lost", ev_lost, 0);
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      step(8'hFF, 1, 0);
      if (sw_stable == 8'hFF) lat = c;
    end
    chk("rst_latency", lat, 2 + DEFF);
    got.delete();
    for (int c = 0; c < 14; c++) begin
      if (ev_valid) got.push_back(ev_data);
      step(8'hFF, 1, 0);
    end
    chk("rst_ev_count", got.size(), 8);
    foreach (got[k]) chk($sformatf("rst_ev%0d", k), got[k], {1'b1, 3'(k)});

    // random activity against the model
    for (int c = 0; c < 400; c++) begin
      logic [7:0] s;
      s = SWI;
      if ($urandom_range(3) == 0) s = s ^ 8'($urandom);
      step(s, $urandom_range(2) != 0, $urandom_range(199) == 0);
    end
    repeat (30) step(SWI, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
